// File: rtl/encoder_if.sv
// Request/index bus between a requester and the registered priority encoder.
// The multi_hot signal exists only when ENCODER_MULTI_HOT_EN is defined.
interface encoder_if #(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = $clog2(IN_WIDTH)
);
   logic                 en;
   logic [IN_WIDTH-1:0]  encoder_in;
   logic [OUT_WIDTH-1:0] encoder_out;
   logic                 valid;
`ifdef ENCODER_MULTI_HOT_EN
   logic                 multi_hot;

   modport master (output en, output encoder_in,
                   input encoder_out, input valid, input multi_hot);
   modport slave  (input en, input encoder_in,
                   output encoder_out, output valid, output multi_hot);
`else
   modport master (output en, output encoder_in,
                   input encoder_out, input valid);
   modport slave  (input en, input encoder_in,
                   output encoder_out, output valid);
`endif
endinterface

// File: rtl/encoder.sv
// Registered MSB-priority encoder: one cycle from sampled request vector to index/valid.
// Optional multi_hot flag enabled by defining ENCODER_MULTI_HOT_EN.
module encoder #(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
   input logic     clk,
   input logic     rst,
   encoder_if.slave bus
);

   function automatic logic [OUT_WIDTH-1:0] msb_index(input logic [IN_WIDTH-1:0] v);
      logic [OUT_WIDTH-1:0] idx;
      idx = '0;
      // Ascending scan so the highest set bit overwrites any lower one.
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (v[i]) idx = OUT_WIDTH'(i);
      end
      return idx;
   endfunction

   logic [OUT_WIDTH-1:0] idx_p0;
   logic                 vld_p0;
   logic [OUT_WIDTH-1:0] idx_p1;
   logic                 vld_p1;

   always_comb begin
      idx_p0 = msb_index(bus.encoder_in);
      vld_p0 = |bus.encoder_in;
   end

   // p0 -> p1: capture register, reset wins over enable
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_p1 <= '0;
         vld_p1 <= 1'b0;
      end else if (bus.en) begin
         idx_p1 <= idx_p0;
         vld_p1 <= vld_p0;
      end
   end

   assign bus.encoder_out = idx_p1;
   assign bus.valid       = vld_p1;

`ifdef ENCODER_MULTI_HOT_EN
   function automatic logic two_or_more(input logic [IN_WIDTH-1:0] v);
      // Clearing the lowest set bit leaves something only if two or more were set.
      return (v & (v - 1'b1)) != '0;
   endfunction

   logic mh_p0;
   logic mh_p1;

   always_comb mh_p0 = two_or_more(bus.encoder_in);

   always_ff @(posedge clk) begin
      if (rst)         mh_p1 <= 1'b0;
      else if (bus.en) mh_p1 <= mh_p0;
   end

   assign bus.multi_hot = mh_p1;
`endif

endmodule

// File: tb/tb_encoder.sv
// Directed-vector bench for encoder: 4-input default instance plus a 5-input instance.
module tb_encoder;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   encoder_if #(.IN_WIDTH(4)) if4 ();
   encoder_if #(.IN_WIDTH(5)) if5 ();

   encoder #(.IN_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
   encoder #(.IN_WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one sample on the 4-bit instance, clock it, then check the registered result.
   task automatic step4(input string tag, input logic r, input logic e, input logic [3:0] v,
                        input logic [1:0] exp_out, input logic exp_vld, input logic exp_mh);
      rst            = r;
      if4.en         = e;
      if4.encoder_in = v;
      @(posedge clk);
      #1;
      check({tag, ".out"}, 32'(if4.encoder_out), 32'(exp_out));
      check({tag, ".valid"}, 32'(if4.valid), 32'(exp_vld));
`ifdef ENCODER_MULTI_HOT_EN
      check({tag, ".multi_hot"}, 32'(if4.multi_hot), 32'(exp_mh));
`else
      if (exp_mh !== 1'b0 && exp_mh !== 1'b1) $display("note: %s has undefined multi_hot expectation", tag);
`endif
   endtask

   task automatic step5(input string tag, input logic [4:0] v,
                        input logic [2:0] exp_out, input logic exp_vld);
      rst            = 1'b0;
      if5.en         = 1'b1;
      if5.encoder_in = v;
      @(posedge clk);
      #1;
      check({tag, ".out"}, 32'(if5.encoder_out), 32'(exp_out));
      check({tag, ".valid"}, 32'(if5.valid), 32'(exp_vld));
   endtask

   initial begin
      rst            = 1'b1;
      if4.en         = 1'b1;
      if4.encoder_in = 4'b1111;
      if5.en         = 1'b0;
      if5.encoder_in = 5'b00000;

      // Reset held two edges with all requests high and enable asserted
      step4("rst0", 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
      step4("rst1", 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
      check("rst.dut5.out", 32'(if5.encoder_out), 32'd0);
      check("rst.dut5.valid", 32'(if5.valid), 32'd0);
      step4("rel", 1'b0, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b1);

      // One-hot sweep
      step4("oh0", 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
      step4("oh1", 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
      step4("oh2", 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
      step4("oh3", 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);

      // Multi-hot: MSB wins
      step4("mh0011", 1'b0, 1'b1, 4'b0011, 2'd1, 1'b1, 1'b1);
      step4("mh0101", 1'b0, 1'b1, 4'b0101, 2'd2, 1'b1, 1'b1);
      step4("mh1001", 1'b0, 1'b1, 4'b1001, 2'd3, 1'b1, 1'b1);
      step4("mh0110", 1'b0, 1'b1, 4'b0110, 2'd2, 1'b1, 1'b1);
      step4("mh1010", 1'b0, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1);
      step4("mh1100", 1'b0, 1'b1, 4'b1100, 2'd3, 1'b1, 1'b1);

      // Zero input after a non-zero sample
      step4("pre0", 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
      step4("zero", 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Enable hold
      step4("cap3", 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
      step4("hold0", 1'b0, 1'b0, 4'b0001, 2'd3, 1'b1, 1'b0);
      step4("hold1", 1'b0, 1'b0, 4'b0001, 2'd3, 1'b1, 1'b0);
      step4("hold2", 1'b0, 1'b0, 4'b0001, 2'd3, 1'b1, 1'b0);
      step4("resume", 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);

      // Hold a multi-hot result, then reset with en low: reset must still win
      step4("mhcap", 1'b0, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b1);
      step4("rst_en0", 1'b1, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0);
      step4("post_rst_hold", 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0);
      step4("post_rst_cap", 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);

      // Non-power-of-two width
      step5("w5_10000", 5'b10000, 3'd4, 1'b1);
      step5("w5_00110", 5'b00110, 3'd2, 1'b1);
      step5("w5_11111", 5'b11111, 3'd4, 1'b1);
      step5("w5_00000", 5'b00000, 3'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end
endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- Registered priority encoder: converts a one-hot or multi-hot input vector into the binary index of its highest set bit.
- Default configuration is 4 inputs to a 2-bit index.
- Used wherever a request/select vector must be reduced to an index, for example arbiter grant or mux select.
- Outputs are registered, one clock of latency, with a valid flag that distinguishes "index 0" from "no bit set".

Parameters:
- IN_WIDTH, 4, number of input request bits; integer ≥ 2.
- OUT_WIDTH, $clog2(IN_WIDTH), width of the encoded index; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  capture enable; when low, all outputs hold their value.
- encoder_in  input  IN_WIDTH  request vector, bit i = request i.
- encoder_out  output  OUT_WIDTH  index of the highest set bit of encoder_in, registered.
- valid  output  1  high when the registered sample had at least one bit set.
- multi_hot  output  1  present only with ENCODER_MULTI_HOT_EN; high when the registered sample had two or more bits set.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates occur on the rising edge of clk; no asynchronous paths.
- Reset: when rst=1 at a rising edge:
  - encoder_out <= 0, valid <= 0, multi_hot <= 0.
  - rst has priority over en.
  - Reset asserted mid-stream discards the pending sample. First valid result appears one cycle after the first en=1 edge following reset release.
- Capture: when rst=0 and en=1 at a rising edge:
  - encoder_out <= index of the most significant 1 in encoder_in (MSB priority).
  - valid <= |encoder_in.
- Latency is exactly 1 cycle from input sample to output; throughput is one sample per cycle.
- Hold: when rst=0 and en=0, all outputs keep their previous values.
- All-zero input: encoder_out <= 0, valid <= 0. Consumers must qualify encoder_out with valid.
- One-hot input 2^k: encoder_out = k.
- Multi-hot input: lower set bits are ignored. Examples for IN_WIDTH=4: 0011→1, 0101→2, 0110→2, 1001→3, 1010→3, 1100→3, 1111→3.
- Non-power-of-two IN_WIDTH: unused index codes are never produced.
- Output is purely a function of the last captured sample; no other internal state.
- No X propagation from the unregistered path: the combinational priority logic must default its result to 0.

Optional Feature:
- Macro: ENCODER_MULTI_HOT_EN.
- When defined:
  - The multi_hot output port exists.
  - Registered with the same rst/en rules as the other outputs.
  - multi_hot <= 1 when popcount(encoder_in) ≥ 2, else 0.
  - Reset value is 0.
- When not defined:
  - The port and its logic are absent.
  - encoder_out and valid behaviour is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with encoder_in=4'b1111, en=1 → encoder_out=0, valid=0, multi_hot=0. Release rst → next edge gives encoder_out=3, valid=1.
- One-hot sweep, en=1, one value per cycle: 0001, 0010, 0100, 1000 → one cycle later, per sample:
  - encoder_out = 0, 1, 2, 3.
  - valid = 1.
  - multi_hot = 0.
- Multi-hot priority: 0011, 0101, 1001, 0110, 1010, 1100 → encoder_out = 1, 2, 3, 2, 3, 3, each valid=1, multi_hot=1.
- Zero input: encoder_in=0000 after 0100 → encoder_out=0, valid=0, multi_hot=0.
- Enable hold: capture 1000 (out=3), then en=0 while driving 0001 for 3 cycles → outputs stay out=3, valid=1. Set en=1 → next cycle out=0.
- Parameter check: IN_WIDTH=5 (OUT_WIDTH=3) with inputs 10000 and 00110 → encoder_out = 4 and 2 respectively, valid=1.
